// File: rtl/prime_pkg.sv
// Shared types and constants for the prime evaluator and its BCD converter.
package prime_pkg;

  localparam int NUM_W      = 10;
  localparam int BCD_DIGITS = 3;

  localparam logic [3:0] DIG_PRIME     = 4'h1;
  localparam logic [3:0] DIG_COMPOSITE = 4'hC;
  localparam logic [3:0] DIG_ERR       = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DIV,
    S_TEST,
    S_BCD,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_COMPOSITE,
    RES_PRIME,
    RES_ERR
  } res_t;

endpackage

// File: rtl/prime_eval_bin2bcd_seq.sv
// Sequential double-dabble converter: load on start, then one shift per cycle.
// done pulses in the cycle after the last shift; bcd holds until the next start.
module bin2bcd_seq
  import prime_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_W-1:0]        bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int SR_W = 4*BCD_DIGITS + NUM_W;

  logic [SR_W-1:0] sr, sr_adj;
  logic            active;
  logic [3:0]      cnt;

  // add-3 correction on every BCD nibble that would overflow on the next shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sr[NUM_W+4*i +: 4] >= 4'd5)
        sr_adj[NUM_W+4*i +: 4] = sr[NUM_W+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr     <= '0;
      active <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr     <= {{(4*BCD_DIGITS){1'b0}}, bin};
        cnt    <= '0;
        active <= 1'b1;
      end else if (active) begin
        sr  <= {sr_adj[SR_W-2:0], 1'b0};
        cnt <= cnt + 4'd1;
        if (cnt == 4'(NUM_W-1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign bcd = sr[SR_W-1 -: 4*BCD_DIGITS];

endmodule

// File: rtl/prime_eval.sv
// Trial-division prime test plus BCD formatting for a 4-digit display; results held between runs.
// Optional PRIME_AUTO_START_EN: a change of number_in while idle starts an evaluation by itself.
module prime_eval
  import prime_pkg::*;
#(
  parameter int MAX_VAL = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_W-1:0] number_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             is_prime,
  output logic [3:0]       digit3,
  output logic [3:0]       digit2,
  output logic [3:0]       digit1,
  output logic [3:0]       digit0
);

  localparam logic [NUM_W-1:0] MAX_N = NUM_W'(MAX_VAL);

  state_t state, state_nxt;
  res_t   res, res_nxt;

  logic [NUM_W-1:0] n, q;
  logic [4:0]       d, rem, rem_sub, rem_nxt;
  logic [3:0]       cnt;
  logic [5:0]       d_p1, rem_sh;
  logic [9:0]       sq_cur;
  logic [11:0]      sq_nxt;
  logic             go, accept, div_init, d_inc, bcd_start, bcd_done;
  logic [4*BCD_DIGITS-1:0] bcd;

`ifdef PRIME_AUTO_START_EN
  logic [NUM_W-1:0] last_val;
  assign go = !done && (start || (number_in != last_val));
`else
  assign go = start && !done;
`endif

  assign sq_cur = {5'b0, d} * {5'b0, d};
  assign d_p1   = {1'b0, d} + 6'd1;
  assign sq_nxt = {6'b0, d_p1} * {6'b0, d_p1};

  // one restoring-division step; low 5 bits suffice since the result is below d
  assign rem_sh  = {rem, q[NUM_W-1]};
  assign rem_sub = rem_sh[4:0] - d;
  assign rem_nxt = (rem_sh >= {1'b0, d}) ? rem_sub : rem_sh[4:0];

  always_comb begin
    state_nxt = state;
    res_nxt   = res;
    accept    = 1'b0;
    div_init  = 1'b0;
    d_inc     = 1'b0;
    case (state)
      S_IDLE: if (go) begin
        state_nxt = S_LOAD;
        accept    = 1'b1;
      end
      S_LOAD: state_nxt = S_CHECK;
      S_CHECK: begin
        if (n > MAX_N) begin
          state_nxt = S_DONE;
          res_nxt   = RES_ERR;
        end else if (n < 10'd2) begin
          state_nxt = S_BCD;
          res_nxt   = RES_COMPOSITE;
        end else if (sq_cur <= n) begin
          state_nxt = S_DIV;
          div_init  = 1'b1;
        end else begin
          state_nxt = S_BCD;
          res_nxt   = RES_PRIME;
        end
      end
      S_DIV: if (cnt == 4'(NUM_W-1)) state_nxt = S_TEST;
      S_TEST: begin
        if (rem == 5'd0) begin
          state_nxt = S_BCD;
          res_nxt   = RES_COMPOSITE;
        end else begin
          d_inc = 1'b1;
          if (sq_nxt <= {2'b00, n}) begin
            state_nxt = S_DIV;
            div_init  = 1'b1;
          end else begin
            state_nxt = S_BCD;
            res_nxt   = RES_PRIME;
          end
        end
      end
      S_BCD:  if (bcd_done) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // converter loads on the edge that enters BCD so the state lasts exactly 11 cycles
  assign bcd_start = (state_nxt == S_BCD) && (state != S_BCD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res      <= RES_COMPOSITE;
      n        <= '0;
      q        <= '0;
      d        <= '0;
      rem      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_prime <= 1'b0;
      digit3   <= 4'h0;
      digit2   <= 4'h0;
      digit1   <= 4'h0;
      digit0   <= 4'h0;
    end else begin
      res  <= res_nxt;
      done <= (state == S_DONE);
      if (accept) begin
        n    <= number_in;
        busy <= 1'b1;
      end
      if (state == S_LOAD) d <= 5'd2;
      if (d_inc)           d <= d + 5'd1;
      if (div_init) begin
        rem <= '0;
        q   <= n;
        cnt <= '0;
      end else if (state == S_DIV) begin
        rem <= rem_nxt;
        q   <= {q[NUM_W-2:0], 1'b0};
        cnt <= cnt + 4'd1;
      end
      if (state == S_DONE) begin
        busy     <= 1'b0;
        is_prime <= (res == RES_PRIME);
        if (res == RES_ERR) begin
          digit3 <= DIG_ERR;
          digit2 <= DIG_ERR;
          digit1 <= DIG_ERR;
          digit0 <= DIG_ERR;
        end else begin
          digit3 <= (res == RES_PRIME) ? DIG_PRIME : DIG_COMPOSITE;
          digit2 <= bcd[11:8];
          digit1 <= bcd[7:4];
          digit0 <= bcd[3:0];
        end
      end
    end
  end

`ifdef PRIME_AUTO_START_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_val <= '0;
    else if (accept) last_val <= number_in;
  end
`endif

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start),
    .bin   (n),
    .done  (bcd_done),
    .bcd   (bcd)
  );

endmodule

// File: tb/tb_prime_eval.sv
// Scoreboard bench for prime_eval: expected latency/flag/digits queued at start, checked at done.
module tb_prime_eval;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] number_in;
  logic       start;
  logic       busy, done, is_prime;
  logic [3:0] digit3, digit2, digit1, digit0;

  typedef struct {
    int         n;
    int         lat;
    logic       ip;
    logic [15:0] dig;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prime_eval dut (
    .clk       (clk),
    .reset     (reset),
    .number_in (number_in),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .is_prime  (is_prime),
    .digit3    (digit3),
    .digit2    (digit2),
    .digit1    (digit1),
    .digit0    (digit0)
  );

  function automatic exp_t model(input int n);
    exp_t e;
    int   k = 0;
    bit   comp = 0;
    int   dv = 2;
    e.n = n;
    if (n > 999) begin
      e.lat = 3;
      e.ip  = 1'b0;
      e.dig = 16'hFFFF;
      return e;
    end
    while (n >= 2 && dv * dv <= n && !comp) begin
      k++;
      if (n % dv == 0) comp = 1;
      dv++;
    end
    e.ip  = (n >= 2) && !comp;
    e.lat = 14 + 11 * k;
    e.dig = {(e.ip ? 4'h1 : 4'hC), 4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    return e;
  endfunction

  task automatic issue(input int n);
    @(negedge clk);
    number_in = 10'(n);
    start     = 1'b1;
    sb.push_back(model(n));
  endtask

  // inj: cycle at which a stray start for value 5 is injected (-1 = none)
  task automatic wait_result(input string name, input int inj, input bit coincide);
    exp_t e;
    int   lat = 0;
    bit   got = 0;
    bit   overlap = 0;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries, need 1", name);
      return;
    end
    e = sb[0];
    @(posedge clk);
    #1 start = 1'b0;
    while (!got && lat < 500) begin
      @(posedge clk);
      #1 lat++;
      if (done && busy) overlap = 1;
      if (lat == inj) begin
        start     = 1'b1;
        number_in = 10'd5;
      end else if (lat == inj + 1) begin
        start     = 1'b0;
        number_in = 10'(e.n);
      end
      if (done === 1'b1) got = 1;
    end
    void'(sb.pop_front());
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles, need done at %0d", name, lat, e.lat);
      return;
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d, need %0d", name, lat, e.lat);
    end
    checks++;
    if (is_prime !== e.ip) begin
      errors++;
      $display("FAIL %s is_prime: got %b, need %b", name, is_prime, e.ip);
    end
    checks++;
    if ({digit3, digit2, digit1, digit0} !== e.dig) begin
      errors++;
      $display("FAIL %s digits: got %h, need %h", name, {digit3, digit2, digit1, digit0}, e.dig);
    end
    checks++;
    if (overlap) begin
      errors++;
      $display("FAIL %s busy_done_overlap: got 1, need 0", name);
    end
    if (coincide) begin
      start     = 1'b1;
      number_in = 10'd5;
      @(posedge clk);
      #1 start  = 1'b0;
      number_in = 10'(e.n);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s start_on_done: busy got %b, need 0", name, busy);
      end
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    number_in = 10'd0;
    repeat (3) @(posedge clk);
    #1 checks++;
    if ({busy, done, is_prime, digit3, digit2, digit1, digit0} !== 19'd0) begin
      errors++;
      $display("FAIL reset_values: got %h, need 0",
               {busy, done, is_prime, digit3, digit2, digit1, digit0});
    end
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: busy/done got %b, need 00", {busy, done});
    end
  endtask

  task automatic test_small();
    for (int v = 0; v < 4; v++) begin
      issue(v);
      wait_result($sformatf("small_%0d", v), -1, 1'b0);
    end
  endtask

  task automatic test_prime();
    issue(2);
    wait_result("prime_2", -1, 1'b0);
    issue(997);
    wait_result("prime_997", -1, 1'b0);
  endtask

  task automatic test_composite();
    issue(221);
    wait_result("comp_221", -1, 1'b0);
    issue(4);
    wait_result("comp_4", -1, 1'b0);
    issue(561);
    wait_result("comp_561", -1, 1'b0);
  endtask

  task automatic test_out_of_range();
    issue(1000);
    wait_result("oor_1000", -1, 1'b0);
    issue(1023);
    wait_result("oor_1023", -1, 1'b0);
  endtask

  task automatic test_ignore_start();
    issue(997);
    wait_result("busy_start_ignored", 50, 1'b0);
  endtask

  task automatic test_back_to_back();
    issue(13);
    wait_result("b2b_13", -1, 1'b1);
    issue(25);
    wait_result("b2b_25", -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    issue(997);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #1 reset  = 1'b1;
    number_in = 10'd0;
    void'(sb.pop_front());
    #1 checks++;
    if ({busy, done, is_prime, digit3, digit2, digit1, digit0} !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h, need 0",
               {busy, done, is_prime, digit3, digit2, digit1, digit0});
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_discard: done/busy seen got 1, need 0");
    end
    issue(13);
    wait_result("after_reset_13", -1, 1'b0);
  endtask

`ifdef PRIME_AUTO_START_EN
  task automatic test_auto();
    int pulses = 0;
    @(negedge clk);
    number_in = 10'd7;
    sb.push_back(model(7));
    wait_result("auto_7", -1, 1'b0);
    @(negedge clk);
    number_in = 10'd11;
    sb.push_back(model(11));
    wait_result("auto_11", -1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1 if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL auto_hold: extra done pulses got %0d, need 0", pulses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_small();
    test_prime();
    test_composite();
    test_out_of_range();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef PRIME_AUTO_START_EN
    test_auto();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prime_eval.md
# prime_eval

Sequential prime evaluator and digit formatter; sits directly upstream of the four-digit seven-segment driver. Captures a 10-bit binary value on a start request, tests primality by iterative trial division, converts the value to BCD, and presents four registered 4-bit digit codes (status plus three decimal digits) with a done pulse. Digits hold steady between evaluations so the display never shows partial results.

## Interface
- MAX_VAL, 999: largest accepted input; must be ≤ 999; larger values are flagged out of range
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- number_in  in  10  value to evaluate; sampled only when a start is accepted
- start  in  1  request pulse; level-sampled each cycle
- busy  out  1  high from the accepting edge until done
- done  out  1  one-cycle pulse; results valid from this cycle
- is_prime  out  1  1 = last evaluated value is prime
- digit3  out  4  status code: 4'h1 prime, 4'hC composite or <2, 4'hF out of range
- digit2..digit0  out  4 each  BCD hundreds, tens, units (4'hF each if out of range)

## Operation
- Reset values: busy 0, done 0, is_prime 0, all digits 4'h0; FSM in IDLE.
- States: IDLE, LOAD, CHECK, DIV, TEST, BCD, DONE.
- IDLE: start=1 → LOAD; n ← number_in, busy ← 1. start while busy is ignored, with no queuing.
- LOAD → CHECK: if n > MAX_VAL → DONE with out-of-range result. If n < 2 → BCD with composite. Otherwise d ← 2 → DIV if d·d ≤ n, else BCD with prime.
- DIV: 10-step restoring division n mod d, one quotient bit per cycle; 5-bit divisor; d·d is a combinational 5×5 product.
- TEST (1 cycle): remainder 0 → BCD with composite (early exit). Else d ← d+1; if d·d ≤ n → DIV, else → BCD with prime.
- BCD: 1 load cycle plus 10 double-dabble shift cycles, producing hundreds/tens/units.
- DONE (1 cycle): all outputs update together, done=1, busy=0, then → IDLE.
- Outputs hold their last values until the next DONE.
- Reset mid-evaluation: immediate return to IDLE with all outputs at reset values; the in-flight evaluation is discarded.

## Timing
- Latency L is counted from the edge that samples start=1 to the cycle with done=1.
- In-range values: L = 14 + 11·k, where k = number of divisors tried.
- Out-of-range values: L = 3.
- Examples: n=0/1/2/3 → 14; n=4 → 25; n=221 → 146; n=997 → 344 (worst case).
- Earliest next start: the cycle after done. A start coincident with done is ignored.
- done and busy are never high together.

## Configuration
- PRIME_AUTO_START_EN defined: an internal register tracks the last evaluated value. In IDLE, number_in differing from it raises an internal start, so no external start is needed. External start is still honoured.
- PRIME_AUTO_START_EN undefined: evaluation only on external start; no tracking register.

## Structure
- Shared package prime_pkg holds:
  - FSM state enum
  - digit code constants: DIG_PRIME=4'h1, DIG_COMPOSITE=4'hC, DIG_ERR=4'hF
  - NUM_W=10
  - BCD_DIGITS=3
- Sub-module bin2bcd_seq: sequential double-dabble converter with start/done, 11 cycles, reused by BCD state.
- Division datapath stays inline.

## Test plan
- Reset, then n=0 and start → L=14, is_prime 0, digits C,0,0,0.
- n=2 start → L=14, is_prime 1, digits 1,0,0,2; then n=997 → L=344, digits 1,9,9,7.
- n=221 (13·17) → L=146, is_prime 0, digits C,2,2,1; n=4 → L=25, digits C,0,0,4.
- n=1000 → L=3, is_prime 0, digits F,F,F,F.
- n=997 start, second start and number_in=5 at cycle 50 → ignored, result still 997; reset at cycle 100 → all outputs 0, busy 0, no done.
- PRIME_AUTO_START_EN: number_in 7→11 with start held 0 → one evaluation, digits 1,0,1,1; value held → no further done pulses.
